// File: rtl/dcache_pkg.sv
// Common types for the direct-mapped write-through data cache.
// State encodings come from the shared header so every user agrees on them.
package dcache_pkg;
`include "dcache_defs.v"

  typedef enum logic [`DCACHE_ST_W-1:0] {
    ST_IDLE   = `DCACHE_IDLE,
    ST_REFILL = `DCACHE_REFILL,
    ST_WRITE  = `DCACHE_WRITE
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Width of a field that may legitimately be zero bits wide; keep at least 1.
  function automatic int min1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dcache_defs.v
// Shared FSM state encodings for the data cache controller.
`ifndef DCACHE_DEFS_V
`define DCACHE_DEFS_V

`define DCACHE_ST_W   2
`define DCACHE_IDLE   2'd0
`define DCACHE_REFILL 2'd1
`define DCACHE_WRITE  2'd2

`endif

// File: rtl/dcache_store.sv
// Valid/tag/data arrays of the cache: combinational read, synchronous writes.
// Reset clears only the valid bits; tags and data keep their contents.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int TAG_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  i_rd_index,
  input  logic [OFF_W-1:0]  i_rd_offset,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_word,
  input  logic              i_word_we,
  input  logic [IDX_W-1:0]  i_word_index,
  input  logic [OFF_W-1:0]  i_word_offset,
  input  logic [DATA_W-1:0] i_word_data,
  input  logic              i_line_we,
  input  logic [IDX_W-1:0]  i_line_index,
  input  logic [TAG_W-1:0]  i_line_tag
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES][WORDS];

  // Read port: lookup of the line addressed by the current CPU request.
  always_comb begin
    o_rd_valid = r_valid[i_rd_index];
    o_rd_tag   = r_tag[i_rd_index];
    o_rd_word  = r_data[i_rd_index][i_rd_offset];
  end

  // Valid bits: cleared by reset, set when a refill finishes its last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_line_we) begin
      r_valid[i_line_index] <= 1'b1;
    end
  end

  // Tag and data arrays: no reset, written by refill beats and store hits.
  always_ff @(posedge clk) begin
    if (i_word_we) begin
      r_data[i_word_index][i_word_offset] <= i_word_data;
    end
    if (i_line_we) begin
      r_tag[i_line_index] <= i_line_tag;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss statistics outputs are enabled with DCACHE_STATS_EN.
//
// Backing-memory handshake: a beat is offered while mem_req is high, with
// mem_we/mem_addr/mem_wdata held stable; it completes in the cycle where
// mem_req and mem_ack are both high. mem_ack is ignored while mem_req is low.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memread,
  input  logic        memwrite,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  o_dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int OFF_W    = min1_clog2(WORDS);
  localparam int IDX_W    = $clog2(LINES);
  localparam int TAG_W    = 30 - OFF_BITS - IDX_W;

  state_t           r_state;
  state_t           w_state_next;
  logic [OFF_W-1:0] r_beat;
  logic             r_wr_done;

  logic [29:0]      w_word_addr;
  logic [29:0]      w_line_base;
  logic [OFF_W-1:0] w_offset;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic             w_last_beat;

  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_word;
  logic             w_hit;

  logic             w_word_we;
  logic [OFF_W-1:0] w_word_off;
  logic [31:0]      w_word_data;
  logic             w_line_we;
  logic             w_hit_evt;
  logic             w_miss_evt;
  logic             w_unused_addr;

  // Address split into offset / index / tag of the word address.
  always_comb begin
    w_word_addr = addr[31:2];
    w_line_base = w_word_addr & ~30'(WORDS - 1);
    w_offset    = OFF_W'(w_word_addr & 30'(WORDS - 1));
    w_index     = IDX_W'(w_word_addr >> OFF_BITS);
    w_tag       = TAG_W'(w_word_addr >> (OFF_BITS + IDX_W));
    w_last_beat = (r_beat == OFF_W'(WORDS - 1));
    w_hit       = w_rd_valid && (w_rd_tag == w_tag);
  end

  assign w_unused_addr = ^addr[1:0];
  assign o_dbg_state   = r_state;

  dcache_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .OFF_W (OFF_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk           (clk),
    .reset         (reset),
    .i_rd_index    (w_index),
    .i_rd_offset   (w_offset),
    .o_rd_valid    (w_rd_valid),
    .o_rd_tag      (w_rd_tag),
    .o_rd_word     (w_rd_word),
    .i_word_we     (w_word_we),
    .i_word_index  (w_index),
    .i_word_offset (w_word_off),
    .i_word_data   (w_word_data),
    .i_line_we     (w_line_we),
    .i_line_index  (w_index),
    .i_line_tag    (w_tag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Refill beat counter: advances on each read ack, back to 0 after the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat <= '0;
    end else if ((r_state == ST_REFILL) && mem_ack) begin
      r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
    end
  end

  // Marks the cycle after a store completes: the held store request is
  // ignored so the pipeline advances and the store is not issued twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= (r_state == ST_WRITE) && mem_ack;
    end
  end

  // Next-state, CPU-side and memory-side outputs; all zero while in reset.
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    rdata        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    w_word_we    = 1'b0;
    w_word_off   = w_offset;
    w_word_data  = wdata;
    w_line_we    = 1'b0;
    w_hit_evt    = 1'b0;
    w_miss_evt   = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_wr_done) begin
            if (memwrite) begin
              stall        = 1'b1;
              w_state_next = ST_WRITE;
            end else if (memread) begin
              if (w_hit) begin
                rdata     = w_rd_word;
                w_hit_evt = 1'b1;
              end else begin
                stall        = 1'b1;
                w_miss_evt   = 1'b1;
                w_state_next = ST_REFILL;
              end
            end
          end
        end
        ST_REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {w_line_base | 30'(r_beat), 2'b00};
          if (mem_ack) begin
            w_word_we   = 1'b1;
            w_word_off  = r_beat;
            w_word_data = mem_rdata;
            if (w_last_beat) begin
              w_line_we    = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {addr[31:2], 2'b00};
          mem_wdata = wdata;
          if (mem_ack) begin
            w_word_we    = w_hit;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_fill_done;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Hit/miss counters; the hit that completes a refilled load is not a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_done  <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_fill_done <= (r_state == ST_REFILL) && mem_ack && w_last_beat;
      if (w_hit_evt && !r_fill_done) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_evt) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_hit_evt ^ w_miss_evt;
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a transaction-level cache/memory model predicts
// beats, stall lengths and load data; one compare process checks every cycle.
module tb_dcache;
  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        memread, memwrite, stall, mem_req, mem_we, mem_ack;
  logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  dcache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .memread     (memread),
    .memwrite    (memwrite),
    .rdata       (rdata),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .o_dbg_state (dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // ---------------- model ----------------
  logic [64:0] exp_q[$];                 // {we, addr, wdata} expected beats
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];
  logic [31:0] mem_m   [bit [31:0]];
  logic [31:0] obs_addr[$];
  logic [31:0] exp_rdata = '0;
  bit          chk_rd = 1'b0;
  int          ack_delay = 0;
  int          ack_count = 0;
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'h0 : mem_word(mem_addr);
          wait_cnt  = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic [64:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("reset_ctl", {stall, mem_req, mem_we}, 0);
        chk("reset_data", mem_addr | mem_wdata | rdata, 0);
      end else begin
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", mem_addr, 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_q[0];
            chk("beat_we", mem_we, e[64]);
            chk("beat_addr", mem_addr, e[63:32]);
            if (e[64]) chk("beat_wdata", mem_wdata, e[31:0]);
            if (mem_ack) begin
              void'(exp_q.pop_front());
              obs_addr.push_back(mem_addr);
              ack_count++;
            end
          end
        end else if (!memread && !memwrite) begin
          chk("idle_outputs", {stall, rdata}, 0);
        end
        if (memread && !memwrite && !stall && chk_rd) begin
          chk("load_rdata", rdata, exp_rdata);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(negedge clk);
    memread  = 1'b0;
    memwrite = 1'b0;
    chk_rd   = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One CPU access; returns number of stall cycles seen and the final rdata.
  task automatic op(input bit is_wr, input bit also_rd, input logic [31:0] a,
                    input logic [31:0] d, input int delay, input string name,
                    output int stalls, output logic [31:0] rd);
    int unsigned ua, idx, off, tg, base;
    bit hit;
    int exp_stall;
    ua   = a;
    idx  = (ua / (4 * WORDS)) % LINES;
    off  = (ua / 4) % WORDS;
    tg   = ua / (4 * WORDS * LINES);
    base = ua - (ua % (4 * WORDS));
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    ack_delay = delay;
    addr      = a;
    wdata     = d;
    memwrite  = is_wr;
    memread   = is_wr ? also_rd : 1'b1;
    if (is_wr) begin
      exp_q.push_back({1'b1, ua - (ua % 4), d});
      mem_m[ua - (ua % 4)] = d;
      if (hit) m_data[idx][off] = d;
      exp_stall = 1 + (delay + 1);
      chk_rd    = 1'b0;
    end else begin
      if (!hit) begin
        for (int b = 0; b < WORDS; b++) begin
          exp_q.push_back({1'b0, base + 4 * b, 32'h0});
          m_data[idx][b] = mem_word(base + 4 * b);
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_misses++;
        exp_stall = 1 + WORDS * (delay + 1);
      end else begin
        m_hits++;
        exp_stall = 0;
      end
      exp_rdata = m_data[idx][off];
      chk_rd    = 1'b1;
    end
    #3;
    stalls = 0;
    while (stall && stalls < 500) begin
      stalls++;
      @(negedge clk);
      #3;
    end
    chk({name, "_stall_cycles"}, stalls, exp_stall);
    rd = rdata;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] lit_addr[4];
  initial begin : stimulus
    int stalls, base_ac, n;
    logic [31:0] rd;
    reset    = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("post_reset_stall", stall, 0);
    chk("post_reset_mem_req", mem_req, 0);
    chk("post_reset_mem_addr", mem_addr, 0);
    chk("post_reset_rdata", rdata, 0);

    // Cold miss on 0x100: four read beats, five stall cycles.
    obs_addr.delete();
    op(1'b0, 1'b0, 32'h100, 32'h0, 0, "ld100_miss", stalls, rd);
    chk("ld100_stalls_lit", stalls, 5);
    chk("ld100_rdata_lit", rd, 32'hC0DE0100);
    lit_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    chk("ld100_beats", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("ld100_beat_addr", obs_addr[i], lit_addr[i]);

    // Hit in the freshly filled line.
    op(1'b0, 1'b0, 32'h104, 32'h0, 0, "ld104_hit", stalls, rd);
    chk("ld104_stalls_lit", stalls, 0);
    chk("ld104_rdata_lit", rd, 32'hC0DE0104);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_lit", hit_count, 1);
    chk("stats_miss_lit", miss_count, 1);
`endif

    // Store hit with a slow ack, then read back.
    obs_addr.delete();
    op(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 2, "st104_hit", stalls, rd);
    chk("st104_stalls_lit", stalls, 4);
    chk("st104_beats", obs_addr.size(), 1);
    idle();
    op(1'b0, 1'b0, 32'h104, 32'h0, 0, "ld104_after_st", stalls, rd);
    chk("ld104_st_rdata_lit", rd, 32'hDEADBEEF);

    // Store miss: one write beat, no allocate; following load misses.
    obs_addr.delete();
    op(1'b1, 1'b0, 32'h2000, 32'h12345678, 0, "st2000_miss", stalls, rd);
    chk("st2000_stalls_lit", stalls, 2);
    chk("st2000_beats", obs_addr.size(), 1);
    op(1'b0, 1'b0, 32'h2000, 32'h0, 0, "ld2000_miss", stalls, rd);
    chk("ld2000_stalls_lit", stalls, 5);
    chk("ld2000_rdata_lit", rd, 32'h12345678);

    // Reset after the second refill ack abandons the refill.
    @(negedge clk);
    base_ac   = ack_count;
    ack_delay = 0;
    addr      = 32'h100;
    memread   = 1'b1;
    chk_rd    = 1'b0;
    for (int b = 0; b < WORDS; b++) exp_q.push_back({1'b0, 32'h100 + 32'(4 * b), 32'h0});
    n = 0;
    while ((ack_count < base_ac + 2) && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("abort_ack_count", ack_count - base_ac, 2);
    @(negedge clk);
    reset   = 1'b1;
    memread = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("abort_mem_req_low", mem_req, 0);
    obs_addr.delete();
    op(1'b0, 1'b0, 32'h100, 32'h0, 0, "ld100_refill_again", stalls, rd);
    chk("refill_again_beats", obs_addr.size(), 4);
    chk("refill_again_rdata_lit", rd, 32'hC0DE0100);

    // Conflict eviction on index 0.
    op(1'b0, 1'b0, 32'h100, 32'h0, 0, "ld100_hit", stalls, rd);
    chk("ld100_hit_stalls_lit", stalls, 0);
    op(1'b0, 1'b0, 32'h500, 32'h0, 0, "ld500_evict", stalls, rd);
    chk("ld500_rdata_lit", rd, 32'hC0DE0500);
    op(1'b0, 1'b0, 32'h100, 32'h0, 0, "ld100_remiss", stalls, rd);
    chk("ld100_remiss_stalls_lit", stalls, 5);

    // Miss with one wait cycle per beat, non-zero offset.
    op(1'b0, 1'b0, 32'h3018, 32'h0, 1, "ld3018_slow", stalls, rd);
    chk("ld3018_stalls_lit", stalls, 9);
    chk("ld3018_rdata_lit", rd, 32'hC0DE3018);

    // memread and memwrite together: the store wins.
    obs_addr.delete();
    op(1'b1, 1'b1, 32'h3014, 32'hA5A50001, 0, "st3014_both", stalls, rd);
    chk("st3014_beats", obs_addr.size(), 1);
    idle();
    op(1'b0, 1'b0, 32'h3014, 32'h0, 0, "ld3014_hit", stalls, rd);
    chk("ld3014_rdata_lit", rd, 32'hA5A50001);
    idle();
    repeat (2) @(negedge clk);
    chk("beats_outstanding", exp_q.size(), 0);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_model", hit_count, m_hits);
    chk("stats_miss_model", miss_count, m_misses);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
